// File: rtl/ppu_requant_wb.sv
// Writeback stage: reads int32 opsums, applies ReLU / rounding shift / zero-point / int8 saturation,
// packs four bytes per word and writes them back to the GLB. One element per RD+CAP pair, one WR per packed word.
module ppu_requant_wb #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [CNT_W-1:0]     i_num_words,
    input  logic [ADDR_W-1:0]    i_src_baseaddr,
    input  logic [ADDR_W-1:0]    i_dst_baseaddr,
    input  logic [4:0]           i_shift,
    input  logic [7:0]           i_zero_point,
    input  logic                 i_relu_en,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [3:0]           o_glb_re,
    output logic [ADDR_W-1:0]    o_glb_r_addr,
    input  logic [DATA_SIZE-1:0] i_glb_r_data,
    output logic [3:0]           o_glb_we,
    output logic [ADDR_W-1:0]    o_glb_w_addr,
    output logic [DATA_SIZE-1:0] o_glb_w_data
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

    localparam logic [CNT_W-1:0]            CNT_ONE = 1;
    localparam logic [DATA_SIZE:0]          RND_ONE = 1;
    localparam logic signed [DATA_SIZE+1:0] SAT_HI  = 127;
    localparam logic signed [DATA_SIZE+1:0] SAT_LO  = -128;

    state_t                r_state, w_state_nx;
    logic [CNT_W-1:0]      r_num, r_cnt, r_word;
    logic [ADDR_W-1:0]     r_src, r_dst;
    logic [4:0]            r_shift;
    logic [7:0]            r_zp;
    logic                  r_relu;
    logic [1:0]            r_lane;
    logic [DATA_SIZE-1:0]  r_pack;

    logic signed [DATA_SIZE-1:0] w_x;
    logic signed [DATA_SIZE:0]   w_x33, w_half, w_rnd, w_y;
    logic signed [DATA_SIZE+1:0] w_z;
    logic [7:0]                  w_byte;
    logic [CNT_W-1:0]            w_cnt_nx;
    logic [3:0]                  w_mask;

    // Rounding add is done one bit wider than the opsum so x + 2^(shift-1) cannot overflow.
    always_comb begin
        w_x    = (r_relu && i_glb_r_data[DATA_SIZE-1]) ? '0 : $signed(i_glb_r_data);
        w_x33  = $signed({w_x[DATA_SIZE-1], w_x});
        w_half = (r_shift == 5'd0) ? '0 : $signed(RND_ONE << (r_shift - 5'd1));
        w_rnd  = w_x33 + w_half;
        w_y    = w_rnd >>> r_shift;
        w_z    = $signed({w_y[DATA_SIZE], w_y}) + $signed({{(DATA_SIZE-6){r_zp[7]}}, r_zp});
        if (w_z > SAT_HI)      w_byte = 8'h7F;
        else if (w_z < SAT_LO) w_byte = 8'h80;
        else                   w_byte = w_z[7:0];
    end

    assign w_cnt_nx = r_cnt + CNT_ONE;

    always_comb begin
        case (r_lane)
            2'd1:    w_mask = 4'b0001;
            2'd2:    w_mask = 4'b0011;
            2'd3:    w_mask = 4'b0111;
            default: w_mask = 4'b1111;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_num   <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_shift <= '0;
            r_zp    <= '0;
            r_relu  <= 1'b0;
            r_lane  <= '0;
            r_pack  <= '0;
        end else begin
            r_state <= w_state_nx;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_num   <= i_num_words;
                    r_src   <= i_src_baseaddr;
                    r_dst   <= i_dst_baseaddr;
                    r_shift <= i_shift;
                    r_zp    <= i_zero_point;
                    r_relu  <= i_relu_en;
                    r_cnt   <= '0;
                    r_word  <= '0;
                    r_lane  <= '0;
                    r_pack  <= '0;
                end
                S_CAP: begin
                    r_pack[{r_lane, 3'b000} +: 8] <= w_byte;
                    r_cnt  <= w_cnt_nx;
                    r_lane <= r_lane + 2'd1;
                end
                S_WR: begin
                    r_pack <= '0;
                    r_word <= r_word + CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    // At WR the lane counter already points past the last filled lane (0 means all four).
    always_comb begin
        w_state_nx   = r_state;
        o_busy       = (r_state != S_IDLE);
        o_done       = 1'b0;
        o_glb_re     = 4'h0;
        o_glb_r_addr = '0;
        o_glb_we     = 4'h0;
        o_glb_w_addr = '0;
        o_glb_w_data = '0;
        case (r_state)
            S_IDLE: if (i_start) w_state_nx = (i_num_words != '0) ? S_RD : S_DONE;
            S_RD: begin
                o_glb_re     = 4'hF;
                o_glb_r_addr = r_src + {{(ADDR_W-CNT_W-2){1'b0}}, r_cnt, 2'b00};
                w_state_nx   = S_CAP;
            end
            S_CAP: w_state_nx = (r_lane == 2'd3 || w_cnt_nx == r_num) ? S_WR : S_RD;
            S_WR: begin
                o_glb_we     = w_mask;
                o_glb_w_addr = r_dst + {{(ADDR_W-CNT_W-2){1'b0}}, r_word, 2'b00};
                o_glb_w_data = r_pack;
                w_state_nx   = (r_cnt == r_num) ? S_DONE : S_RD;
            end
            S_DONE: begin
                o_done     = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ppu_requant_wb.sv
// Scoreboarded bench for ppu_requant_wb: expected reads/writes queued at stimulus time, popped as the DUT strobes.
module tb_ppu_requant_wb;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [15:0] i_num_words;
    logic [31:0] i_src_baseaddr, i_dst_baseaddr;
    logic [4:0]  i_shift;
    logic [7:0]  i_zero_point;
    logic        i_relu_en;
    logic        o_busy, o_done;
    logic [3:0]  o_glb_re, o_glb_we;
    logic [31:0] o_glb_r_addr, o_glb_w_addr, o_glb_w_data;
    logic [31:0] i_glb_r_data;

    int          n_chk = 0;
    int          n_err = 0;
    wr_t         wr_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] vals[$];
    bit   [31:0] mem [bit [31:0]];
    logic [31:0] mon_ra;
    wr_t         mon_w;

    ppu_requant_wb dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_num_words(i_num_words),
        .i_src_baseaddr(i_src_baseaddr), .i_dst_baseaddr(i_dst_baseaddr),
        .i_shift(i_shift), .i_zero_point(i_zero_point), .i_relu_en(i_relu_en),
        .o_busy(o_busy), .o_done(o_done),
        .o_glb_re(o_glb_re), .o_glb_r_addr(o_glb_r_addr), .i_glb_r_data(i_glb_r_data),
        .o_glb_we(o_glb_we), .o_glb_w_addr(o_glb_w_addr), .o_glb_w_data(o_glb_w_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_q(input logic [31:0] raw, input int sh, input int zp, input bit relu);
        longint v;
        v = longint'($signed(raw));
        if (relu && v < 0) v = 0;
        if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
        v = v + zp;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    // GLB model with one-cycle read latency
    always @(posedge clk) begin
        if (o_glb_re != 4'h0)
            i_glb_r_data <= mem.exists(o_glb_r_addr) ? mem[o_glb_r_addr] : 32'hDEADBEEF;
    end

    always @(negedge clk) begin
        if (i_rst) begin
            if (o_glb_re != 4'h0) begin
                if (rd_q.size() == 0) check("rd_unexpected", o_glb_re, 0);
                else begin
                    mon_ra = rd_q.pop_front();
                    check("rd_addr", o_glb_r_addr, mon_ra);
                    check("rd_re", o_glb_re, 4'hF);
                end
            end
            if (o_glb_we != 4'h0) begin
                if (wr_q.size() == 0) check("wr_unexpected", o_glb_we, 0);
                else begin
                    mon_w = wr_q.pop_front();
                    check("wr_addr", o_glb_w_addr, mon_w.addr);
                    check("wr_we", o_glb_we, mon_w.we);
                    check("wr_data", o_glb_w_data, mon_w.data);
                end
            end
        end
    end

    task automatic load_expect(input int n, input logic [31:0] src, input logic [31:0] dst,
                               input int sh, input int zp, input bit relu);
        logic [31:0] pk;
        logic [3:0]  m;
        wr_t         w;
        pk = '0;
        m  = '0;
        for (int k = 0; k < n; k++) begin
            mem[src + 32'(4 * k)] = vals[k];
            rd_q.push_back(src + 32'(4 * k));
            pk[8 * (k % 4) +: 8] = ref_q(vals[k], sh, zp, relu);
            m[k % 4] = 1'b1;
            if (k % 4 == 3 || k == n - 1) begin
                w.addr = dst + 32'(4 * (k / 4));
                w.we   = m;
                w.data = pk;
                wr_q.push_back(w);
                pk = '0;
                m  = '0;
            end
        end
    endtask

    task automatic drive_start(input int n, input logic [31:0] src, input logic [31:0] dst,
                               input int sh, input int zp, input bit relu);
        @(negedge clk);
        i_num_words    = 16'(n);
        i_src_baseaddr = src;
        i_dst_baseaddr = dst;
        i_shift        = 5'(sh);
        i_zero_point   = 8'(zp);
        i_relu_en      = relu;
        i_start        = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    task automatic run_pass(input string nm, input int n, input logic [31:0] src, input logic [31:0] dst,
                            input int sh, input int zp, input bit relu, input int poke);
        int cyc;
        load_expect(n, src, dst, sh, zp, relu);
        drive_start(n, src, dst, sh, zp, relu);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({nm, "_busy"}, o_busy, 1);
            if (cyc == poke) begin
                i_start        = 1'b1;
                i_num_words    = 16'd3;
                i_src_baseaddr = 32'h0;
                i_dst_baseaddr = 32'h40;
                i_shift        = 5'd9;
                i_zero_point   = 8'h33;
                i_relu_en      = ~relu;
            end else begin
                i_start = 1'b0;
            end
            if (o_done) break;
        end
        check({nm, "_done_cycle"}, cyc, 2 * n + (n + 3) / 4 + 1);
        @(negedge clk);
        check({nm, "_done_pulse"}, o_done, 0);
        check({nm, "_idle_busy"}, o_busy, 0);
        check({nm, "_rd_pending"}, rd_q.size(), 0);
        check({nm, "_wr_pending"}, wr_q.size(), 0);
        rd_q.delete();
        wr_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        i_rst = 1'b0; i_start = 1'b0; i_num_words = '0;
        i_src_baseaddr = '0; i_dst_baseaddr = '0;
        i_shift = '0; i_zero_point = '0; i_relu_en = 1'b0;
        i_glb_r_data = '0;
        #2;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_re", o_glb_re, 0);
        check("rst_we", o_glb_we, 0);
        check("rst_raddr", o_glb_r_addr, 0);
        check("rst_waddr", o_glb_w_addr, 0);
        check("rst_wdata", o_glb_w_data, 0);
        repeat (2) @(negedge clk);
        i_rst = 1'b1;

        vals = '{32'd100, 32'hFFFFFFCE, 32'd1000, 32'd7};
        check("model_basic", {ref_q(vals[3], 2, 0, 0), ref_q(vals[2], 2, 0, 0),
                              ref_q(vals[1], 2, 0, 0), ref_q(vals[0], 2, 0, 0)}, 32'h027FF419);
        run_pass("basic", 4, 32'h100, 32'h200, 2, 0, 1'b0, 0);
        run_pass("relu", 4, 32'h100, 32'h200, 2, 0, 1'b1, 0);

        vals = '{32'd10, 32'hFFFFFF38, 32'd3, 32'd130, 32'd0};
        run_pass("partial", 5, 32'h300, 32'h400, 0, -5, 1'b0, 0);

        vals = '{32'h7FFFFFFF};
        run_pass("sat_pos", 1, 32'h500, 32'h600, 0, 0, 1'b0, 0);
        vals = '{32'h80000000};
        run_pass("sat_neg", 1, 32'h500, 32'h604, 0, 0, 1'b0, 0);
        vals = '{32'h7FFFFFFF};
        check("model_sh31", ref_q(vals[0], 31, 0, 0), 8'h01);
        run_pass("sat_sh31", 1, 32'h500, 32'h608, 31, 0, 1'b0, 0);

        vals.delete();
        run_pass("empty", 0, 32'h700, 32'h800, 3, 1, 1'b0, 0);

        vals.delete();
        for (int k = 0; k < 7; k++) vals.push_back($urandom());
        run_pass("inplace", 7, 32'hA00, 32'hA00, 9, -17, 1'b1, 0);

        vals.delete();
        for (int k = 0; k < 6; k++) vals.push_back($urandom_range(0, 4000) - 2000);
        run_pass("start_busy", 6, 32'hFFFFFFF0, 32'hB00, 4, 3, 1'b0, 3);

        // Abort mid-pass: reset lands during CAP of element 2
        vals = '{32'd1, 32'd2, 32'd3, 32'd4};
        load_expect(4, 32'hC00, 32'hD00, 0, 0, 1'b0);
        drive_start(4, 32'hC00, 32'hD00, 0, 0, 1'b0);
        cyc = 0;
        while (cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_rd_seen", rd_q.size(), 1);
        #2 i_rst = 1'b0;
        #1;
        check("abort_busy", o_busy, 0);
        check("abort_done", o_done, 0);
        check("abort_re", o_glb_re, 0);
        check("abort_we", o_glb_we, 0);
        check("abort_wdata", o_glb_w_data, 0);
        check("abort_waddr", o_glb_w_addr, 0);
        rd_q.delete();
        wr_q.delete();
        repeat (2) @(negedge clk);
        i_rst = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_idle", o_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
